// File: rtl/branch_station_if.sv
// Dispatch, CDB, issue and flush signals of the branch reservation station.
// master = dispatch/CDB/branch-unit side, slave = the station itself.
interface branch_station_if #(
    parameter int unsigned TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic             in_src1_rdy;
    logic             in_src2_rdy;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [TAG_W-1:0] in_id;
    logic [31:0]      in_new_pc;
    logic             in_approx;
    logic             in_jr;
    logic [2:0]       in_funct;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_src1;
    logic [31:0]      issue_src2;
    logic [TAG_W-1:0] issue_id;
    logic [31:0]      issue_new_pc;
    logic             issue_approx;
    logic             issue_jr;
    logic [2:0]       issue_funct;

    logic             flush;

    modport master (
        output in_valid, in_src1_rdy, in_src2_rdy, in_src1, in_src2,
               in_id, in_new_pc, in_approx, in_jr, in_funct,
               cdb_valid, cdb_tag, cdb_data, issue_ready, flush,
        input  in_ready, issue_valid, issue_src1, issue_src2, issue_id,
               issue_new_pc, issue_approx, issue_jr, issue_funct
    );

    modport slave (
        input  in_valid, in_src1_rdy, in_src2_rdy, in_src1, in_src2,
               in_id, in_new_pc, in_approx, in_jr, in_funct,
               cdb_valid, cdb_tag, cdb_data, issue_ready, flush,
        output in_ready, issue_valid, issue_src1, issue_src2, issue_id,
               issue_new_pc, issue_approx, issue_jr, issue_funct
    );
endinterface

// File: rtl/branch_station.sv
// Branch reservation station: DEPTH entries, CDB operand wakeup, single issue port.
// Define BRANCH_STATION_AGE_ORDER_EN to issue the oldest eligible entry instead of lowest index.
module branch_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic            clk,
    input  logic            nreset,
    branch_station_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             s1_rdy;
        logic [31:0]      s1;
        logic             s2_rdy;
        logic [31:0]      s2;
        logic [TAG_W-1:0] id;
        logic [31:0]      new_pc;
        logic             approx;
        logic             jr;
        logic [2:0]       funct;
    } entry_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] sel_q, sel_d;

    logic [DEPTH-1:0] eligible;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    logic             xfer;
    entry_t           new_ent;

`ifdef BRANCH_STATION_AGE_ORDER_EN
    // older_q[i][j] set means entry i was dispatched before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic             oldest;
`endif

    always_comb begin
        eligible   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eligible[i] = valid_q[i] & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
`ifdef BRANCH_STATION_AGE_ORDER_EN
        oldest = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            oldest = eligible[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j] && !older_q[i][j]) oldest = 1'b0;
            end
            if (oldest && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
`else
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (eligible[i] && !pick_found) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
`endif
        // A stalled offer keeps its entry even if a better candidate wakes up.
        sel_idx = lock_q ? sel_q : pick_idx;
    end

    assign bus.in_ready     = free_found;
    assign bus.issue_valid  = |eligible;
    assign bus.issue_src1   = ent_q[sel_idx].s1;
    assign bus.issue_src2   = ent_q[sel_idx].s2;
    assign bus.issue_id     = ent_q[sel_idx].id;
    assign bus.issue_new_pc = ent_q[sel_idx].new_pc;
    assign bus.issue_approx = ent_q[sel_idx].approx;
    assign bus.issue_jr     = ent_q[sel_idx].jr;
    assign bus.issue_funct  = ent_q[sel_idx].funct;

    assign accept = bus.in_valid & free_found;
    assign xfer   = bus.issue_valid & bus.issue_ready;

    always_comb begin
        new_ent.s1_rdy = bus.in_src1_rdy;
        new_ent.s1     = bus.in_src1;
        new_ent.s2_rdy = bus.in_src2_rdy;
        new_ent.s2     = bus.in_src2;
        new_ent.id     = bus.in_id;
        new_ent.new_pc = bus.in_new_pc;
        new_ent.approx = bus.in_approx;
        new_ent.jr     = bus.in_jr;
        new_ent.funct  = bus.in_funct;
        if (bus.cdb_valid && !bus.in_src1_rdy && bus.in_src1[TAG_W-1:0] == bus.cdb_tag) begin
            new_ent.s1_rdy = 1'b1;
            new_ent.s1     = bus.cdb_data;
        end
        if (bus.cdb_valid && !bus.in_src2_rdy && bus.in_src2[TAG_W-1:0] == bus.cdb_tag) begin
            new_ent.s2_rdy = 1'b1;
            new_ent.s2     = bus.cdb_data;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        lock_d  = bus.issue_valid & ~bus.issue_ready & ~bus.flush;
        sel_d   = sel_idx;
`ifdef BRANCH_STATION_AGE_ORDER_EN
        older_d = older_q;
`endif
        if (bus.cdb_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!ent_q[i].s1_rdy && ent_q[i].s1[TAG_W-1:0] == bus.cdb_tag) begin
                    ent_d[i].s1_rdy = 1'b1;
                    ent_d[i].s1     = bus.cdb_data;
                end
                if (!ent_q[i].s2_rdy && ent_q[i].s2[TAG_W-1:0] == bus.cdb_tag) begin
                    ent_d[i].s2_rdy = 1'b1;
                    ent_d[i].s2     = bus.cdb_data;
                end
            end
        end
        // The slot freed by an issue is not in free_idx until the next cycle.
        if (xfer) valid_d[sel_idx] = 1'b0;
        if (accept) begin
            valid_d[free_idx] = 1'b1;
            ent_d[free_idx]   = new_ent;
`ifdef BRANCH_STATION_AGE_ORDER_EN
            for (int unsigned j = 0; j < DEPTH; j++) begin
                older_d[free_idx][j] = 1'b0;
                older_d[j][free_idx] = 1'b1;
            end
`endif
        end
        if (bus.flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q <= '0;
            lock_q  <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            lock_q  <= lock_d;
            sel_q   <= sel_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
`ifdef BRANCH_STATION_AGE_ORDER_EN
        older_q <= older_d;
`endif
    end
endmodule

// File: tb/tb_branch_station.sv
// Scoreboard bench for branch_station: expected issues are queued at dispatch and
// compared by a monitor on every issue transfer.
module tb_branch_station;
    localparam int unsigned TAG_W = 6;

    typedef struct {
        logic [TAG_W-1:0] id;
        logic [31:0]      src1;
        logic [31:0]      src2;
        logic [31:0]      pc;
        logic             approx;
        logic             jr;
        logic [2:0]       funct;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb [$];

    branch_station_if #(.TAG_W(TAG_W)) bus ();

    branch_station #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic drive(input logic [TAG_W-1:0] id, input logic r1, input logic [31:0] s1,
                         input logic r2, input logic [31:0] s2, input logic [31:0] pc,
                         input logic ap, input logic jr, input logic [2:0] fn);
        bus.in_valid    = 1'b1;
        bus.in_id       = id;
        bus.in_src1_rdy = r1;
        bus.in_src1     = s1;
        bus.in_src2_rdy = r2;
        bus.in_src2     = s2;
        bus.in_new_pc   = pc;
        bus.in_approx   = ap;
        bus.in_jr       = jr;
        bus.in_funct    = fn;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    function automatic exp_t mk(input logic [TAG_W-1:0] id, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] pc,
                                input logic ap, input logic jr, input logic [2:0] fn);
        exp_t e;
        e.id = id; e.src1 = s1; e.src2 = s2; e.pc = pc;
        e.approx = ap; e.jr = jr; e.funct = fn;
        return e;
    endfunction

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (nreset && bus.issue_valid && bus.issue_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", {58'd0, bus.issue_id}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("iss_id",     64'(bus.issue_id),     64'(e.id));
                check("iss_src1",   64'(bus.issue_src1),   64'(e.src1));
                check("iss_src2",   64'(bus.issue_src2),   64'(e.src2));
                check("iss_pc",     64'(bus.issue_new_pc), 64'(e.pc));
                check("iss_flags",  64'({bus.issue_approx, bus.issue_jr, bus.issue_funct}),
                                    64'({e.approx, e.jr, e.funct}));
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_src1_rdy = 1'b0; bus.in_src2_rdy = 1'b0;
        bus.in_src1 = '0; bus.in_src2 = '0; bus.in_id = '0; bus.in_new_pc = '0;
        bus.in_approx = 1'b0; bus.in_jr = 1'b0; bus.in_funct = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.issue_ready = 1'b0; bus.flush = 1'b0;

        // Reset state
        #2;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        #20 nreset = 1'b1;
        tick();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_issue_valid", 64'(bus.issue_valid), 64'd0);

        // Both operands ready: offered the next cycle, freed one cycle later
        bus.issue_ready = 1'b1;
        drive(6'd3, 1'b1, 32'h11, 1'b1, 32'h22, 32'h100, 1'b1, 1'b0, 3'd2);
        sb.push_back(mk(6'd3, 32'h11, 32'h22, 32'h100, 1'b1, 1'b0, 3'd2));
        tick();
        idle();
        @(negedge clk);
        check("t1_issue_valid", 64'(bus.issue_valid), 64'd1);
        check("t1_issue_id", 64'(bus.issue_id), 64'd3);
        tick();
        @(negedge clk);
        check("t1_freed", 64'(bus.issue_valid), 64'd0);

        // Wakeup of src1 by a later CDB broadcast
        tick();
        drive(6'd5, 1'b0, 32'd9, 1'b1, 32'h55, 32'h200, 1'b0, 1'b1, 3'd5);
        sb.push_back(mk(6'd5, 32'h1234, 32'h55, 32'h200, 1'b0, 1'b1, 3'd5));
        tick();
        idle();
        @(negedge clk);
        check("t2_wait0", 64'(bus.issue_valid), 64'd0);
        tick();
        cdb(6'd9, 32'h1234);
        @(negedge clk);
        check("t2_wait1", 64'(bus.issue_valid), 64'd0);
        tick();
        idle();
        @(negedge clk);
        check("t2_woken", 64'(bus.issue_valid), 64'd1);
        check("t2_src1", 64'(bus.issue_src1), 64'h1234);
        drain("t2_drain");

        // Wakeup in the dispatch cycle itself
        tick();
        drive(6'd12, 1'b1, 32'hA, 1'b0, 32'd7, 32'h300, 1'b0, 1'b0, 3'd1);
        cdb(6'd7, 32'hFF);
        sb.push_back(mk(6'd12, 32'hA, 32'hFF, 32'h300, 1'b0, 1'b0, 3'd1));
        tick();
        idle();
        @(negedge clk);
        check("t3_eligible", 64'(bus.issue_valid), 64'd1);
        check("t3_src2", 64'(bus.issue_src2), 64'hFF);
        drain("t3_drain");

        // Fill, ignored extra dispatch, flush beats dispatch and wakeup
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(6'(20 + k), 1'b0, 32'(30 + k), 1'b1, 32'h0, 32'h400, 1'b0, 1'b0, 3'd0);
            tick();
        end
        drive(6'd40, 1'b1, 32'h1, 1'b1, 32'h2, 32'h500, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        check("t4_full_in_ready", 64'(bus.in_ready), 64'd0);
        check("t4_full_issue_valid", 64'(bus.issue_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t4_extra_ignored", 64'(bus.issue_valid), 64'd0);
        drive(6'd41, 1'b1, 32'h1, 1'b1, 32'h2, 32'h600, 1'b0, 1'b0, 3'd0);
        cdb(6'd30, 32'hDEAD);
        bus.flush = 1'b1;
        tick();
        idle();
        @(negedge clk);
        check("t4_flush_in_ready", 64'(bus.in_ready), 64'd1);
        check("t4_flush_issue_valid", 64'(bus.issue_valid), 64'd0);
        tick();
        @(negedge clk);
        check("t4_flush_nothing_left", 64'(bus.issue_valid), 64'd0);

        // Stalled offer stays on its entry while a lower index wakes up
        tick();
        bus.issue_ready = 1'b0;
        drive(6'd60, 1'b0, 32'd5, 1'b1, 32'h60, 32'h700, 1'b0, 1'b0, 3'd3);
        tick();
        drive(6'd61, 1'b1, 32'h61, 1'b1, 32'h62, 32'h704, 1'b1, 1'b1, 3'd4);
        sb.push_back(mk(6'd61, 32'h61, 32'h62, 32'h704, 1'b1, 1'b1, 3'd4));
        sb.push_back(mk(6'd60, 32'h77, 32'h60, 32'h700, 1'b0, 1'b0, 3'd3));
        tick();
        idle();
        @(negedge clk);
        check("t5_first_offer", 64'(bus.issue_id), 64'd61);
        tick();
        cdb(6'd5, 32'h77);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_stall_id", 64'(bus.issue_id), 64'd61);
            tick();
        end
        bus.issue_ready = 1'b1;
        drain("t5_drain");

        // Older entry in a higher index vs younger entry in index 0
        tick();
        drive(6'd1, 1'b1, 32'h101, 1'b1, 32'h102, 32'h800, 1'b0, 1'b0, 3'd0);
        sb.push_back(mk(6'd1, 32'h101, 32'h102, 32'h800, 1'b0, 1'b0, 3'd0));
        tick();
        drive(6'd2, 1'b0, 32'd8, 1'b1, 32'h202, 32'h804, 1'b0, 1'b1, 3'd1);
        tick();
        drive(6'd3, 1'b1, 32'h301, 1'b1, 32'h302, 32'h808, 1'b1, 1'b0, 3'd2);
        cdb(6'd8, 32'h88);
`ifdef BRANCH_STATION_AGE_ORDER_EN
        sb.push_back(mk(6'd2, 32'h88, 32'h202, 32'h804, 1'b0, 1'b1, 3'd1));
        sb.push_back(mk(6'd3, 32'h301, 32'h302, 32'h808, 1'b1, 1'b0, 3'd2));
`else
        sb.push_back(mk(6'd3, 32'h301, 32'h302, 32'h808, 1'b1, 1'b0, 3'd2));
        sb.push_back(mk(6'd2, 32'h88, 32'h202, 32'h804, 1'b0, 1'b1, 3'd1));
`endif
        tick();
        idle();
        drain("t6_drain");

        // Asynchronous reset in the middle of an offer
        tick();
        bus.issue_ready = 1'b0;
        drive(6'd62, 1'b1, 32'h1, 1'b1, 32'h2, 32'h900, 1'b0, 1'b0, 3'd0);
        tick();
        idle();
        @(negedge clk);
        check("t7_offer", 64'(bus.issue_valid), 64'd1);
        #2 nreset = 1'b0;
        #1;
        check("t7_async_issue_valid", 64'(bus.issue_valid), 64'd0);
        check("t7_async_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        bus.issue_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("t7_no_old_issue", 64'(bus.issue_valid), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
